// File: rtl/core_cf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_cf_arbiter
// Description : Fixed-priority arbiter for the fetch control-flow-change bus.
//               The requesters are trap (highest priority), exec CFU, then
//               debug (lowest). The redirect target and the grant are
//               registered and held stable until fetch accepts. Each accepted
//               redirect produces a one-cycle pipeline flush.
//               Optional macro CORE_CF_ARB_PERF_EN adds 32-bit redirect
//               performance counters (perf_redirects, perf_trap_redirects).
// Revision    : 1.0 - initial release
// ============================================================================
module core_cf_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            trap_ack,

    input  logic            exec_valid,
    input  logic [XLEN-1:0] exec_target,
    output logic            exec_ack,

    input  logic            dbg_valid,
    input  logic [XLEN-1:0] dbg_target,
    output logic            dbg_ack,

    output logic            f_cf_valid,
    input  logic            f_cf_ack,
    output logic [XLEN-1:0] f_cf_target,

    output logic            pipe_flush,
    output logic            arb_busy,
    output logic [1:0]      arb_grant
`ifdef CORE_CF_ARB_PERF_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_trap_redirects
`endif
);

    localparam logic [1:0] c_GRANT_TRAP = 2'd0;
    localparam logic [1:0] c_GRANT_EXEC = 2'd1;
    localparam logic [1:0] c_GRANT_DBG  = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_cf_valid;
    logic [XLEN-1:0]   r_cf_target;
    logic [1:0]        r_grant;

    logic              w_any_req;
    logic [1:0]        w_sel_grant;
    logic [XLEN-1:0]   w_sel_target;
    logic              w_accept;

    // Priority select: trap beats exec, exec beats debug
    always_comb begin
        w_sel_grant  = c_GRANT_DBG;
        w_sel_target = dbg_target;
        if (trap_valid) begin
            w_sel_grant  = c_GRANT_TRAP;
            w_sel_target = trap_target;
        end else if (exec_valid) begin
            w_sel_grant  = c_GRANT_EXEC;
            w_sel_target = exec_target;
        end
    end

    assign w_any_req = trap_valid | exec_valid | dbg_valid;
    // Fetch acks are only meaningful while a redirect is being offered
    assign w_accept  = r_cf_valid & f_cf_ack;

    // Arbitration FSM: IDLE samples requests, BUSY holds the offer until fetch accepts
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state     <= ST_IDLE;
            r_cf_valid  <= 1'b0;
            r_cf_target <= '0;
            r_grant     <= c_GRANT_TRAP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_sel_grant;
                        r_cf_target <= {w_sel_target[XLEN-1:1], 1'b0};
                        r_cf_valid  <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Target and grant stay frozen; late higher-priority
                    // requests wait for the next IDLE sample.
                    if (f_cf_ack) begin
                        r_cf_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_cf_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_cf_valid  = r_cf_valid;
    assign f_cf_target = r_cf_target;
    assign arb_grant   = r_grant;
    assign arb_busy    = r_cf_valid;
    assign pipe_flush  = w_accept;
    assign trap_ack    = w_accept & (r_grant == c_GRANT_TRAP);
    assign exec_ack    = w_accept & (r_grant == c_GRANT_EXEC);
    assign dbg_ack     = w_accept & (r_grant == c_GRANT_DBG);

`ifdef CORE_CF_ARB_PERF_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_trap_redirects;

    // Accepted-redirect counters, free-running with natural 32-bit wrap
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_perf_redirects      <= '0;
            r_perf_trap_redirects <= '0;
        end else if (w_accept) begin
            r_perf_redirects <= r_perf_redirects + 32'd1;
            if (r_grant == c_GRANT_TRAP) begin
                r_perf_trap_redirects <= r_perf_trap_redirects + 32'd1;
            end
        end
    end

    assign perf_redirects      = r_perf_redirects;
    assign perf_trap_redirects = r_perf_trap_redirects;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_cf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_cf_arbiter
// Description : Scoreboard bench for core_cf_arbiter. A reference model
//               predicts each redirect offer (owner, target). A negedge
//               monitor compares the DUT outputs against the head of the
//               expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_cf_arbiter;

    localparam int XLEN = 64;

    typedef struct {
        int              src;
        logic [XLEN-1:0] tgt;
    } exp_t;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic [2:0]      req_v;
    logic [XLEN-1:0] req_t [3];
    logic            trap_ack, exec_ack, dbg_ack;
    logic            f_cf_valid, f_cf_ack, pipe_flush, arb_busy;
    logic [XLEN-1:0] f_cf_target;
    logic [1:0]      arb_grant;
`ifdef CORE_CF_ARB_PERF_EN
    logic [31:0]     perf_redirects, perf_trap_redirects;
    logic [31:0]     m_perf_all, m_perf_trap;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic m_busy;
    int   n_accept = 0;
    logic mon_en = 1'b0;

    core_cf_arbiter #(.XLEN(XLEN)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .trap_valid  (req_v[0]),
        .trap_target (req_t[0]),
        .trap_ack    (trap_ack),
        .exec_valid  (req_v[1]),
        .exec_target (req_t[1]),
        .exec_ack    (exec_ack),
        .dbg_valid   (req_v[2]),
        .dbg_target  (req_t[2]),
        .dbg_ack     (dbg_ack),
        .f_cf_valid  (f_cf_valid),
        .f_cf_ack    (f_cf_ack),
        .f_cf_target (f_cf_target),
        .pipe_flush  (pipe_flush),
        .arb_busy    (arb_busy),
        .arb_grant   (arb_grant)
`ifdef CORE_CF_ARB_PERF_EN
        ,
        .perf_redirects      (perf_redirects),
        .perf_trap_redirects (perf_trap_redirects)
`endif
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: whenever no redirect is outstanding, the
    // highest-priority pending request becomes the next offer
    always @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            m_busy <= 1'b0;
            sb.delete();
        end else if (!m_busy) begin
            for (int i = 0; i < 3; i++) begin
                if (req_v[i]) begin
                    sb.push_back('{i, {req_t[i][XLEN-1:1], 1'b0}});
                    m_busy <= 1'b1;
                    break;
                end
            end
        end else begin
            if (sb.size() != 0) begin
                chk("req_held", {63'd0, req_v[sb[0].src]}, 64'd1);
            end
            if (f_cf_ack) m_busy <= 1'b0;
        end
    end

    // Monitor: compare offer, acks and flush against the scoreboard head
    always @(negedge g_clk) begin
        if (mon_en && !g_reset) begin
            logic [2:0] exp_ack;
            logic       acc;
            acc     = (sb.size() != 0) && f_cf_ack;
            exp_ack = acc ? (3'b001 << sb[0].src) : 3'b000;
            chk("f_cf_valid", {63'd0, f_cf_valid}, {63'd0, (sb.size() != 0)});
            chk("arb_busy", {63'd0, arb_busy}, {63'd0, (sb.size() != 0)});
            chk("acks", {61'd0, dbg_ack, exec_ack, trap_ack}, {61'd0, exp_ack});
            chk("pipe_flush", {63'd0, pipe_flush}, {63'd0, acc});
            if (sb.size() != 0) begin
                chk("f_cf_target", f_cf_target, sb[0].tgt);
                chk("arb_grant", {62'd0, arb_grant}, 64'(sb[0].src));
            end
`ifdef CORE_CF_ARB_PERF_EN
            chk("perf_redirects", {32'd0, perf_redirects}, {32'd0, m_perf_all});
            chk("perf_trap", {32'd0, perf_trap_redirects}, {32'd0, m_perf_trap});
            if (acc) begin
                m_perf_all = m_perf_all + 32'd1;
                if (sb[0].src == 0) m_perf_trap = m_perf_trap + 32'd1;
            end
`endif
            if (acc) begin
                void'(sb.pop_front());
                n_accept++;
            end
        end
    end

    // One random cycle: requesters drop after their ack, else may raise with a fresh target
    task automatic rand_cycle(input int rate);
        logic [2:0] acked;
        @(negedge g_clk);
        acked = {dbg_ack, exec_ack, trap_ack};
        @(posedge g_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acked[i]) begin
                req_v[i] = 1'b0;
            end else if (!req_v[i] && ($urandom_range(0, 3) < rate)) begin
                req_v[i] = 1'b1;
                req_t[i] = {$urandom, $urandom};
            end
        end
        f_cf_ack = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        int waited;
        req_v    = 3'b000;
        req_t[0] = '0;
        req_t[1] = '0;
        req_t[2] = '0;
        f_cf_ack = 1'b0;
        g_reset  = 1'b1;
`ifdef CORE_CF_ARB_PERF_EN
        m_perf_all  = 32'd0;
        m_perf_trap = 32'd0;
`endif
        #1;
        chk("rst_f_cf_valid", {63'd0, f_cf_valid}, 64'd0);
        chk("rst_f_cf_target", f_cf_target, 64'd0);
        chk("rst_arb_grant", {62'd0, arb_grant}, 64'd0);
        chk("rst_arb_busy", {63'd0, arb_busy}, 64'd0);
        chk("rst_flush_acks", {60'd0, pipe_flush, dbg_ack, exec_ack, trap_ack}, 64'd0);
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
        mon_en  = 1'b1;

        // Fetch acks while idle with nothing requested: must be ignored
        f_cf_ack = 1'b1;
        repeat (4) @(negedge g_clk);
        chk("idle_ack_busy", {63'd0, arb_busy}, 64'd0);

        // All three requesters at once, odd targets exercise bit-0 clearing
        @(posedge g_clk);
        #1;
        req_v    = 3'b111;
        req_t[0] = 64'h0000_0000_0000_0101;
        req_t[1] = 64'h0000_0000_8000_0011;
        req_t[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        f_cf_ack = 1'b1;
        waited   = 0;
        while (req_v != 3'b000 && waited < 40) begin
            rand_cycle(0);
            f_cf_ack = 1'b1;
            waited++;
        end
        chk("all3_served", {61'd0, req_v}, 64'd0);
        chk("all3_accepts", 64'(n_accept), 64'd3);

        // Reset while a redirect is outstanding, requester keeps valid
        @(posedge g_clk);
        #1;
        f_cf_ack = 1'b0;
        req_v[2] = 1'b1;
        req_t[2] = 64'h0000_1234_5678_9ABD;
        waited   = 0;
        while (!f_cf_valid && waited < 10) begin
            @(posedge g_clk);
            #1;
            waited++;
        end
        chk("dbg_offered", {63'd0, f_cf_valid}, 64'd1);
        @(posedge g_clk);
        #2;
        g_reset = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, f_cf_valid}, 64'd0);
        chk("midrst_dbg_ack", {63'd0, dbg_ack}, 64'd0);
`ifdef CORE_CF_ARB_PERF_EN
        m_perf_all  = 32'd0;
        m_perf_trap = 32'd0;
`endif
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
        repeat (3) @(negedge g_clk);
        chk("reoffer_target", f_cf_target, 64'h0000_1234_5678_9ABC);

`ifdef CORE_CF_ARB_PERF_EN
        // Preload near the top of the range so the run crosses the wrap
        @(posedge g_clk);
        #2;
        force dut.r_perf_redirects = 32'hFFFF_FFFE;
        #1;
        release dut.r_perf_redirects;
        m_perf_all = 32'hFFFF_FFFE;
`endif

        // Randomized traffic, acks withheld on about a third of cycles
        for (int n = 0; n < 3000; n++) begin
            rand_cycle(1);
        end

        // Drain: no new requests, fetch always accepts
        waited = 0;
        while (req_v != 3'b000 && waited < 40) begin
            rand_cycle(0);
            f_cf_ack = 1'b1;
            waited++;
        end
        repeat (3) @(negedge g_clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_idle", {63'd0, arb_busy}, 64'd0);
        checks++;
        if (n_accept < 100) begin
            errors++;
            $display("FAIL accept_count: got %0d expected at least 100", n_accept);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
